// File: rtl/stage_update_ctrl.sv
// rtl/stage_update_ctrl.sv - stage-filtered update FIFO issuing port-B writes with bounded collision hold
module stage_update_ctrl #(
  parameter int STAGE_ID   = 0,
  parameter int DATA       = 72,
  parameter int ADDR       = 10,
  parameter int STAGE_BITS = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HOLD   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [STAGE_BITS-1:0] upd_stage,
  input  logic [ADDR-1:0]       upd_addr,
  input  logic [DATA-1:0]       upd_data,
  input  logic                  upd_last,
  input  logic                  lk_valid,
  input  logic [ADDR-1:0]       lk_addr,
  output logic                  b_wr,
  output logic [ADDR-1:0]       b_addr,
  output logic [DATA-1:0]       b_din,
  output logic                  busy,
  output logic                  batch_done,
  output logic [15:0]           wr_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [PW:0]           DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]           ONE_C    = (PW+1)'(1);
  localparam logic [HW-1:0]         HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [STAGE_BITS-1:0] MY_STAGE = STAGE_BITS'(STAGE_ID);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  state_t state, state_n;

  logic [ADDR-1:0]       fifo_addr [FIFO_DEPTH];
  logic [DATA-1:0]       fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [HW-1:0]         hold_cnt, hold_n;
  logic                  push, pop, collision;

  assign upd_ready = !rst && (count != DEPTH_C);
  assign busy      = (count != '0) || b_wr;
  // Foreign-stage commands still complete the handshake; they just never reach the FIFO.
  assign push      = upd_valid && upd_ready && (upd_stage == MY_STAGE);
  assign collision = lk_valid && (lk_addr == fifo_addr[rd_ptr]);

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (push || count != '0) state_n = ISSUE;
      end
      ISSUE: begin
        if (count == '0) begin
          state_n = push ? ISSUE : IDLE;
        end else if (collision) begin
          hold_n  = HW'(1);
          state_n = HOLD;
        end else begin
          pop = 1'b1;
        end
      end
      HOLD: begin
        if (collision && hold_cnt < HOLD_LIM) begin
          hold_n = hold_cnt + HW'(1);
        end else begin
          pop    = 1'b1;
          hold_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // A same-edge push keeps the pipeline in ISSUE so back-to-back writes continue.
    if (pop) state_n = (count != ONE_C || push) ? ISSUE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= upd_addr;
      fifo_data[wr_ptr] <= upd_data;
      fifo_last[wr_ptr] <= upd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_cnt   <= '0;
      b_wr       <= 1'b0;
      b_addr     <= '0;
      b_din      <= '0;
      batch_done <= 1'b0;
      wr_count   <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (pop) begin
        b_wr       <= 1'b1;
        b_addr     <= fifo_addr[rd_ptr];
        b_din      <= fifo_data[rd_ptr];
        batch_done <= fifo_last[rd_ptr];
        rd_ptr     <= rd_ptr + PW'(1);
        wr_count   <= wr_count + 16'd1;
      end else begin
        b_wr       <= 1'b0;
        batch_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_update_ctrl.sv
// tb/tb_stage_update_ctrl.sv - vector table, corner sequences and random traffic against a queue model
module tb_stage_update_ctrl;

  localparam int DATA  = 72;
  localparam int ADDR  = 10;
  localparam int SB    = 5;
  localparam int DEPTH = 4;
  localparam int MAXH  = 15;
  localparam int SID   = 0;

  logic            clk = 1'b0;
  logic            rst, upd_valid, upd_ready, upd_last, lk_valid;
  logic [SB-1:0]   upd_stage;
  logic [ADDR-1:0] upd_addr, lk_addr, b_addr;
  logic [DATA-1:0] upd_data, b_din;
  logic            b_wr, busy, batch_done;
  logic [15:0]     wr_count;

  stage_update_ctrl #(
    .STAGE_ID(SID), .DATA(DATA), .ADDR(ADDR), .STAGE_BITS(SB),
    .FIFO_DEPTH(DEPTH), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_stage(upd_stage), .upd_addr(upd_addr), .upd_data(upd_data), .upd_last(upd_last),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
    .busy(busy), .batch_done(batch_done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
    logic            last;
    int              born;
  } ent_t;

  typedef struct {
    logic            r, v, l, lv;
    logic [SB-1:0]   st;
    logic [ADDR-1:0] a, la;
    logic [DATA-1:0] d;
    logic            e_wr, e_bd, e_busy;
    logic [ADDR-1:0] e_addr;
    logic [DATA-1:0] e_din;
    logic [15:0]     e_wc;
  } vec_t;

  ent_t            mq[$];
  vec_t            tbl[$];
  logic [ADDR-1:0] wlog[$];
  int              edge_no = 0;
  int              held = 0;
  logic            m_bwr = 1'b0, m_bd = 1'b0;
  logic [ADDR-1:0] m_baddr = '0;
  logic [DATA-1:0] m_bdin = '0;
  logic [15:0]     m_wc = '0;
  int              vectors = 0;
  int              miscompares = 0;
  logic            dut_acc;

  task automatic chk(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Head becomes writable one edge after it was pushed; it is written unless it collides,
  // and after MAX_HOLD consecutive colliding edges it is written regardless.
  task automatic model_edge();
    logic acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      held = 0; m_bwr = 1'b0; m_bd = 1'b0; m_baddr = '0; m_bdin = '0; m_wc = '0;
    end else begin
      acc = upd_valid && (mq.size() < DEPTH);
      m_bwr = 1'b0;
      m_bd  = 1'b0;
      if (mq.size() > 0 && mq[0].born < edge_no) begin
        if (!(lk_valid && lk_addr == mq[0].addr) || held == MAXH) begin
          m_bwr = 1'b1; m_baddr = mq[0].addr; m_bdin = mq[0].data; m_bd = mq[0].last;
          m_wc = m_wc + 16'd1;
          held = 0;
          void'(mq.pop_front());
        end else begin
          held++;
        end
      end
      if (acc && upd_stage == SB'(SID)) begin
        e.addr = upd_addr; e.data = upd_data; e.last = upd_last; e.born = edge_no;
        mq.push_back(e);
      end
    end
    edge_no++;
  endtask

  task automatic step(input int r, input int v, input int st, input int a,
                      input logic [DATA-1:0] d, input int l, input int lv, input int la);
    rst = 1'(r); upd_valid = 1'(v); upd_stage = SB'(st); upd_addr = ADDR'(a);
    upd_data = d; upd_last = 1'(l); lk_valid = 1'(lv); lk_addr = ADDR'(la);
    #1;
    chk("upd_ready", DATA'(upd_ready), DATA'(r == 0 && mq.size() < DEPTH));
    dut_acc = upd_valid && upd_ready;
    @(posedge clk);
    model_edge();
    #1;
    chk("b_wr", DATA'(b_wr), DATA'(m_bwr));
    chk("b_addr", DATA'(b_addr), DATA'(m_baddr));
    chk("b_din", b_din, m_bdin);
    chk("batch_done", DATA'(batch_done), DATA'(m_bd));
    chk("wr_count", DATA'(wr_count), DATA'(m_wc));
    chk("busy", DATA'(busy), DATA'(mq.size() > 0 || m_bwr));
    if (b_wr) wlog.push_back(b_addr);
  endtask

  function automatic vec_t mk(input int r, input int v, input int st, input int a, input int d,
                              input int l, input int lv, input int la, input int wr, input int ea,
                              input int ed, input int bd, input int wc, input int bz);
    vec_t t;
    t.r = 1'(r); t.v = 1'(v); t.st = SB'(st); t.a = ADDR'(a); t.d = DATA'(d);
    t.l = 1'(l); t.lv = 1'(lv); t.la = ADDR'(la);
    t.e_wr = 1'(wr); t.e_addr = ADDR'(ea); t.e_din = DATA'(ed); t.e_bd = 1'(bd);
    t.e_wc = 16'(wc); t.e_busy = 1'(bz);
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int sent, n, found, base, rr, vv, ss, aa, ll, lv, la;
    logic [DATA-1:0] dd;

    rst = 1'b1; upd_valid = 1'b0; upd_stage = '0; upd_addr = '0; upd_data = '0;
    upd_last = 1'b0; lk_valid = 1'b0; lk_addr = '0;
    @(posedge clk); #1;

    // r v st addr data last lv la | wr addr din bd wc busy
    tbl.push_back(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,'hA1,0,0,0,       0,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,2,'hA2,0,0,0,       1,1,'hA1,0,1,1));
    tbl.push_back(mk(0,1,0,3,'hA3,0,0,0,       1,2,'hA2,0,2,1));
    tbl.push_back(mk(0,1,0,4,'hA4,1,0,0,       1,3,'hA3,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,          1,4,'hA4,1,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,4,'hA4,0,4,0));
    tbl.push_back(mk(0,1,0,'h10,'h55,0,0,0,    0,4,'hA4,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h10,       0,4,'hA4,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h10,       0,4,'hA4,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h10,       0,4,'hA4,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,          1,'h10,'h55,0,5,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,'h10,'h55,0,5,0));
    tbl.push_back(mk(0,1,1,'h11,'h66,0,0,0,    0,'h10,'h55,0,5,0));
    tbl.push_back(mk(0,1,1,'h12,'h67,1,0,0,    0,'h10,'h55,0,5,0));
    tbl.push_back(mk(0,1,0,'h07,'h77,1,0,0,    0,'h10,'h55,0,5,1));
    tbl.push_back(mk(0,1,1,'h13,'h88,0,0,0,    1,'h07,'h77,1,6,1));
    tbl.push_back(mk(0,1,2,'h14,'h99,1,0,0,    0,'h07,'h77,0,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,          0,'h07,'h77,0,6,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(int'(tbl[i].r), int'(tbl[i].v), int'(tbl[i].st), int'(tbl[i].a), tbl[i].d,
           int'(tbl[i].l), int'(tbl[i].lv), int'(tbl[i].la));
      chk($sformatf("row%0d_b_wr", i), DATA'(b_wr), DATA'(tbl[i].e_wr));
      chk($sformatf("row%0d_b_addr", i), DATA'(b_addr), DATA'(tbl[i].e_addr));
      chk($sformatf("row%0d_b_din", i), b_din, tbl[i].e_din);
      chk($sformatf("row%0d_batch_done", i), DATA'(batch_done), DATA'(tbl[i].e_bd));
      chk($sformatf("row%0d_wr_count", i), DATA'(wr_count), DATA'(tbl[i].e_wc));
      chk($sformatf("row%0d_busy", i), DATA'(busy), DATA'(tbl[i].e_busy));
    end

    // Six back-to-back commands while the lookup sits on the first address.
    wlog.delete();
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      step(0, int'(sent < 6), SID, 'h100 + sent, DATA'('h1000 + sent), 0, 1, 'h100);
      if (dut_acc) sent++;
    end
    chk("accepts_until_full", DATA'(sent), DATA'(4));
    chk("no_write_while_held", DATA'(wlog.size()), DATA'(0));
    chk("ready_low_when_full", DATA'(upd_ready), DATA'(0));
    for (int c = 0; c < 30 && wlog.size() < 6; c++) begin
      step(0, int'(sent < 6), SID, 'h100 + sent, DATA'('h1000 + sent), 0, 0, 0);
      if (dut_acc) sent++;
    end
    chk("six_written", DATA'(wlog.size()), DATA'(6));
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk($sformatf("order%0d", i), DATA'(wlog[i]), DATA'('h100 + i));
    step(0, 0, 0, 0, '0, 0, 0, 0);

    // Permanent conflict on the head: forced write after MAX_HOLD hold cycles.
    base = int'(m_wc);
    step(0, 1, SID, 'h020, DATA'('hF0), 0, 1, 'h020);
    n = 0; found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      step(0, 0, 0, 0, '0, 0, 1, 'h020);
      n++;
      if (b_wr) found = 1;
    end
    chk("forced_latency", DATA'(n), DATA'(MAXH + 1));
    chk("forced_count", DATA'(wr_count), DATA'(base + 1));
    step(0, 0, 0, 0, '0, 0, 0, 0);

    // Reset with three entries buffered behind a conflict.
    for (int i = 0; i < 3; i++) step(0, 1, SID, 'h30 + i, DATA'('h300 + i), 0, 1, 'h30);
    step(1, 0, 0, 0, '0, 0, 1, 'h30);
    chk("rst_b_wr", DATA'(b_wr), DATA'(0));
    chk("rst_busy", DATA'(busy), DATA'(0));
    chk("rst_wr_count", DATA'(wr_count), DATA'(0));
    wlog.delete();
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, '0, 0, 0, 0);
    chk("no_write_after_rst", DATA'(wlog.size()), DATA'(0));

    // Random traffic; every third 100-cycle window pins the lookup to the head address.
    for (int c = 0; c < 1500; c++) begin
      rr = int'($urandom_range(0, 199) == 0);
      vv = int'($urandom_range(0, 2) != 0);
      ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : SID;
      aa = int'($urandom_range(0, 7));
      dd = DATA'({$urandom(), $urandom(), $urandom()});
      ll = int'($urandom_range(0, 3) == 0);
      if ((c / 100) % 3 == 2) begin
        lv = 1;
        la = (mq.size() > 0) ? int'(mq[0].addr) : 0;
      end else begin
        lv = int'($urandom_range(0, 1));
        la = int'($urandom_range(0, 7));
      end
      step(rr, vv, ss, aa, dd, ll, lv, la);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_update_ctrl.md
Name: stage_update_ctrl

Overview:
Update controller for one lookup-pipeline stage memory. It accepts table-update commands from the control-plane stream and keeps only those addressed to its STAGE_ID. Accepted commands are buffered in a small FIFO and issued as single-cycle writes on the memory's port B. Writes are deferred while the lookup datapath reads the same address on port A, with a bounded hold so updates cannot starve.

Parameters:
STAGE_ID, 0, stage index this instance serves; commands with another upd_stage are discarded
DATA, 72, memory word width
ADDR, 10, memory address width
STAGE_BITS, 5, width of upd_stage
FIFO_DEPTH, 4, command buffer entries; power of two, >= 2
MAX_HOLD, 15, max consecutive collision holds before a write is forced; >= 1

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous, active-high reset
upd_valid  input  1  update command valid
upd_ready  output  1  controller can accept a command
upd_stage  input  STAGE_BITS  target stage of the command
upd_addr  input  ADDR  target word address
upd_data  input  DATA  word to write
upd_last  input  1  final command of an update batch
lk_valid  input  1  lookup read on port A this cycle
lk_addr  input  ADDR  port A read address this cycle
b_wr  output  1  port B write strobe
b_addr  output  ADDR  port B address
b_din  output  DATA  port B write data
busy  output  1  FIFO non-empty or write in progress
batch_done  output  1  one-cycle pulse, coincident with b_wr, when the entry flagged upd_last is written
wr_count  output  16  total writes issued; wraps 65535 -> 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state: upd_ready=0 during any cycle with rst=1, and =1 in the first cycle after rst drops. b_wr=0, b_addr=0, b_din=0, busy=0, batch_done=0, wr_count=0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-operation: buffered entries and any pending hold are discarded. No write is issued in the cycle after the reset edge.
- Handshake: a command is accepted on a rising edge where upd_valid & upd_ready.
- upd_ready = !full, taken from registered occupancy. No push occurs when the FIFO is full, even if a pop happens in the same cycle.
- Foreign stage: an accepted command with upd_stage != STAGE_ID is consumed and dropped. It does not change the FIFO, counters or batch_done, and its upd_last is ignored.
- FIFO: stores {addr, data, last}; circular pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same edge are allowed.
- No bypass: an entry pushed into an empty FIFO is first eligible for issue at the next edge.
- Latency without conflict: acceptance at edge k gives b_wr=1 in the cycle after edge k+1. Sustained throughput is 1 write/cycle.
- Output registers: b_wr, b_addr, b_din and batch_done are registered. b_wr is a 1-cycle pulse per entry. b_addr and b_din hold their last values while b_wr=0.
- FSM states: IDLE, ISSUE, HOLD, evaluated at each edge.
  - IDLE: FIFO empty, b_wr=0. Go to ISSUE when the FIFO becomes non-empty.
  - ISSUE, no collision (collision means lk_valid & lk_addr == head.addr): pop the head and register the write. Stay in ISSUE if entries remain, otherwise go to IDLE.
  - ISSUE, collision: no write; hold counter := 1; go to HOLD.
  - HOLD, collision with hold counter < MAX_HOLD: increment hold counter; no write.
  - HOLD, no collision or hold counter == MAX_HOLD: write the head (a forced write when the counter reached MAX_HOLD), clear hold counter, then go to ISSUE or IDLE as in the no-collision case.
- Collision check uses the current-cycle lk_valid/lk_addr only. Non-head entries are not checked.
- wr_count: increments on every edge that registers b_wr=1; modulo 2^16.
- batch_done: asserted with the b_wr of the entry whose last=1.
- busy = (FIFO not empty) | b_wr.
- Write order always equals acceptance order of own-stage commands.

Test Plan:
- Reset then 4 own-stage commands (addr 1..4, data 0xA1..0xA4, last on the 4th), lk_valid=0 -> b_wr in 4 consecutive cycles, first one 2 cycles after the first acceptance; addresses 1,2,3,4 in order; batch_done with addr 4; wr_count=4.
- 6 back-to-back commands with FIFO_DEPTH=4 and lk_valid held on the head address -> upd_ready drops after 4 accepts; no write until hold clears; all 6 eventually written in order.
- Head addr 0x010 with lk_valid=1, lk_addr=0x010 for 3 cycles -> b_wr held exactly 3 cycles, write occurs the cycle after the conflict ends.
- Permanent conflict on the head with MAX_HOLD=15 -> forced write after 15 hold cycles; wr_count increments.
- Interleaved upd_stage=STAGE_ID+1 commands, one with last=1 -> all accepted (upd_ready stays 1) but none written; batch_done never pulses for them.
- rst asserted for 1 cycle with 3 entries buffered -> no further b_wr; busy=0 and upd_ready=1 the cycle after rst drops; wr_count=0.
